axi_rd_arb2: RTL and testbench

AXI_RD_ARB2 -- requirements
Module: axi_rd_arb2

---
 rtl/axi_rd_arb2.sv | 155 +++++++++++++++
 tb/tb_axi_rd_arb2.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rd_arb2.sv
// Two-requester AXI read arbiter: round-robin on AR, one outstanding burst,
// R beats routed back to the owning requester with an rlast/beat-count check.
module axi_rd_arb2 #(
    parameter int PARAMETER_ADDRESS_SIZE = 32,
    parameter int PARAMETER_WORD_SIZE    = 64,
    parameter int PARAMETER_ID_SIZE      = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              s0_axi_arvalid,
    output logic                              s0_axi_arready,
    input  logic [PARAMETER_ADDRESS_SIZE-1:0] s0_axi_araddr,
    input  logic [PARAMETER_ID_SIZE-1:0]      s0_axi_arid,
    input  logic [7:0]                        s0_axi_arlen,
    input  logic [2:0]                        s0_axi_arsize,
    input  logic [1:0]                        s0_axi_arburst,
    output logic                              s0_axi_rvalid,
    output logic                              s0_axi_rlast,
    output logic [PARAMETER_WORD_SIZE-1:0]    s0_axi_rdata,
    output logic [1:0]                        s0_axi_rresp,
    output logic [PARAMETER_ID_SIZE-1:0]      s0_axi_rid,
    input  logic                              s0_axi_rready,
    input  logic                              s1_axi_arvalid,
    output logic                              s1_axi_arready,
    input  logic [PARAMETER_ADDRESS_SIZE-1:0] s1_axi_araddr,
    input  logic [PARAMETER_ID_SIZE-1:0]      s1_axi_arid,
    input  logic [7:0]                        s1_axi_arlen,
    input  logic [2:0]                        s1_axi_arsize,
    input  logic [1:0]                        s1_axi_arburst,
    output logic                              s1_axi_rvalid,
    output logic                              s1_axi_rlast,
    output logic [PARAMETER_WORD_SIZE-1:0]    s1_axi_rdata,
    output logic [1:0]                        s1_axi_rresp,
    output logic [PARAMETER_ID_SIZE-1:0]      s1_axi_rid,
    input  logic                              s1_axi_rready,
    output logic                              m_axi_arvalid,
    input  logic                              m_axi_arready,
    output logic [PARAMETER_ADDRESS_SIZE-1:0] m_axi_araddr,
    output logic [PARAMETER_ID_SIZE-1:0]      m_axi_arid,
    output logic [7:0]                        m_axi_arlen,
    output logic [2:0]                        m_axi_arsize,
    output logic [1:0]                        m_axi_arburst,
    input  logic                              m_axi_rvalid,
    input  logic                              m_axi_rlast,
    input  logic [PARAMETER_WORD_SIZE-1:0]    m_axi_rdata,
    input  logic [1:0]                        m_axi_rresp,
    input  logic [PARAMETER_ID_SIZE-1:0]      m_axi_rid,
    output logic                              m_axi_rready,
    output logic                              grant,
    output logic                              busy,
    output logic                              rlast_err
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t                            state;
    state_t                            state_nxt;
    logic                              last_grant;
    logic                              winner;
    logic                              accept;
    logic                              r_hs;
    logic                              last_beat;
    logic [7:0]                        beat_cnt;
    logic [PARAMETER_ADDRESS_SIZE-1:0] ar_addr_q;
    logic [PARAMETER_ID_SIZE-1:0]      ar_id_q;
    logic [7:0]                        ar_len_q;
    logic [2:0]                        ar_size_q;
    logic [1:0]                        ar_burst_q;

    assign m_axi_arvalid = (state == ADDR);
    assign m_axi_araddr  = ar_addr_q;
    assign m_axi_arid    = ar_id_q;
    assign m_axi_arlen   = ar_len_q;
    assign m_axi_arsize  = ar_size_q;
    assign m_axi_arburst = ar_burst_q;
    assign busy          = (state != IDLE);

    assign s0_axi_rdata  = m_axi_rdata;
    assign s0_axi_rresp  = m_axi_rresp;
    assign s0_axi_rid    = m_axi_rid;
    assign s0_axi_rlast  = m_axi_rlast & s0_axi_rvalid;
    assign s1_axi_rdata  = m_axi_rdata;
    assign s1_axi_rresp  = m_axi_rresp;
    assign s1_axi_rid    = m_axi_rid;
    assign s1_axi_rlast  = m_axi_rlast & s1_axi_rvalid;

    // On a tie the requester that did not own the previous burst wins.
    always_comb begin
        state_nxt      = state;
        accept         = 1'b0;
        s0_axi_arready = 1'b0;
        s1_axi_arready = 1'b0;
        m_axi_rready   = 1'b0;
        s0_axi_rvalid  = 1'b0;
        s1_axi_rvalid  = 1'b0;
        r_hs           = 1'b0;
        last_beat      = 1'b0;
        winner         = (s0_axi_arvalid && s1_axi_arvalid) ? ~last_grant : s1_axi_arvalid;
        case (state)
            IDLE: begin
                if (s0_axi_arvalid || s1_axi_arvalid) begin
                    accept         = 1'b1;
                    s0_axi_arready = ~winner;
                    s1_axi_arready = winner;
                    state_nxt      = ADDR;
                end
            end
            ADDR: begin
                if (m_axi_arready) state_nxt = DATA;
            end
            DATA: begin
                m_axi_rready  = grant ? s1_axi_rready : s0_axi_rready;
                s0_axi_rvalid = m_axi_rvalid & ~grant;
                s1_axi_rvalid = m_axi_rvalid & grant;
                r_hs          = m_axi_rvalid & m_axi_rready;
                last_beat     = m_axi_rlast || (beat_cnt == 8'd0);
                if (r_hs && last_beat) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // beat_cnt holds at zero so a late rlast cannot wrap it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            grant      <= 1'b0;
            beat_cnt   <= 8'd0;
            rlast_err  <= 1'b0;
            ar_addr_q  <= '0;
            ar_id_q    <= '0;
            ar_len_q   <= 8'd0;
            ar_size_q  <= 3'd0;
            ar_burst_q <= 2'd0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                grant      <= winner;
                ar_addr_q  <= winner ? s1_axi_araddr  : s0_axi_araddr;
                ar_id_q    <= winner ? s1_axi_arid    : s0_axi_arid;
                ar_len_q   <= winner ? s1_axi_arlen   : s0_axi_arlen;
                ar_size_q  <= winner ? s1_axi_arsize  : s0_axi_arsize;
                ar_burst_q <= winner ? s1_axi_arburst : s0_axi_arburst;
            end
            if (state == ADDR && m_axi_arready) beat_cnt <= ar_len_q;
            if (r_hs) begin
                if (beat_cnt != 8'd0) beat_cnt <= beat_cnt - 8'd1;
                if (m_axi_rlast != (beat_cnt == 8'd0)) rlast_err <= 1'b1;
                if (last_beat) last_grant <= grant;
            end
        end
    end

endmodule

// File: tb/tb_axi_rd_arb2.sv
// Scoreboard bench for axi_rd_arb2: two requester drivers, a memory slave
// model, and expected beats queued at each upstream AR handshake.
module tb_axi_rd_arb2;
    localparam int AW = 32;
    localparam int DW = 64;
    localparam int IW = 4;

    typedef struct {
        logic [AW-1:0] addr;
        logic [7:0]    len;
        logic [IW-1:0] id;
    } req_t;

    typedef struct {
        logic          port;
        logic [DW-1:0] data;
        logic [1:0]    resp;
        logic [IW-1:0] id;
        logic          last;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          s0_axi_arvalid, s0_axi_arready, s1_axi_arvalid, s1_axi_arready;
    logic [AW-1:0] s0_axi_araddr, s1_axi_araddr, m_axi_araddr;
    logic [IW-1:0] s0_axi_arid, s1_axi_arid, m_axi_arid;
    logic [7:0]    s0_axi_arlen, s1_axi_arlen, m_axi_arlen;
    logic [2:0]    s0_axi_arsize, s1_axi_arsize, m_axi_arsize;
    logic [1:0]    s0_axi_arburst, s1_axi_arburst, m_axi_arburst;
    logic          s0_axi_rvalid, s0_axi_rlast, s0_axi_rready;
    logic          s1_axi_rvalid, s1_axi_rlast, s1_axi_rready;
    logic [DW-1:0] s0_axi_rdata, s1_axi_rdata, m_axi_rdata;
    logic [1:0]    s0_axi_rresp, s1_axi_rresp, m_axi_rresp;
    logic [IW-1:0] s0_axi_rid, s1_axi_rid, m_axi_rid;
    logic          m_axi_arvalid, m_axi_arready;
    logic          m_axi_rvalid, m_axi_rlast, m_axi_rready;
    logic          grant, busy, rlast_err;

    axi_rd_arb2 #(
        .PARAMETER_ADDRESS_SIZE(AW),
        .PARAMETER_WORD_SIZE(DW),
        .PARAMETER_ID_SIZE(IW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s0_axi_arvalid(s0_axi_arvalid), .s0_axi_arready(s0_axi_arready),
        .s0_axi_araddr(s0_axi_araddr), .s0_axi_arid(s0_axi_arid),
        .s0_axi_arlen(s0_axi_arlen), .s0_axi_arsize(s0_axi_arsize),
        .s0_axi_arburst(s0_axi_arburst),
        .s0_axi_rvalid(s0_axi_rvalid), .s0_axi_rlast(s0_axi_rlast),
        .s0_axi_rdata(s0_axi_rdata), .s0_axi_rresp(s0_axi_rresp),
        .s0_axi_rid(s0_axi_rid), .s0_axi_rready(s0_axi_rready),
        .s1_axi_arvalid(s1_axi_arvalid), .s1_axi_arready(s1_axi_arready),
        .s1_axi_araddr(s1_axi_araddr), .s1_axi_arid(s1_axi_arid),
        .s1_axi_arlen(s1_axi_arlen), .s1_axi_arsize(s1_axi_arsize),
        .s1_axi_arburst(s1_axi_arburst),
        .s1_axi_rvalid(s1_axi_rvalid), .s1_axi_rlast(s1_axi_rlast),
        .s1_axi_rdata(s1_axi_rdata), .s1_axi_rresp(s1_axi_rresp),
        .s1_axi_rid(s1_axi_rid), .s1_axi_rready(s1_axi_rready),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arid(m_axi_arid),
        .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
        .m_axi_arburst(m_axi_arburst),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rlast(m_axi_rlast),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rid(m_axi_rid), .m_axi_rready(m_axi_rready),
        .grant(grant), .busy(busy), .rlast_err(rlast_err)
    );

    always #5 clk = ~clk;

    req_t          pend0[$];
    req_t          pend1[$];
    beat_t         exp_q[$];
    int            grant_log[$];
    int            total = 0;
    int            bad = 0;
    int            beats_seen = 0;
    int            stall_cnt = 0;
    int            early_at = -1;
    bit            rr_toggle = 1'b0;
    logic          tb_last = 1'b1;

    logic          s0_hs, s1_hs, mar_hs, mr_hs, mr_last, mar_seen, u0, u1, port, exp_win;
    logic [AW-1:0] cap_addr, prev_araddr;
    logic [7:0]    cap_len;
    logic [IW-1:0] cap_id;
    logic          sl_active;
    logic [AW-1:0] sl_addr;
    logic [7:0]    sl_len, sl_beat;
    logic [IW-1:0] sl_id;
    logic          prev_up_hs, prev_port, prev_mar_wait, prev_last;
    req_t          prev_req;
    beat_t         eb;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic p, input logic [AW-1:0] addr, input logic [7:0] len,
                                 input logic [IW-1:0] id);
        req_t r;
        r.addr = addr;
        r.len  = len;
        r.id   = id;
        if (p) pend1.push_back(r);
        else   pend0.push_back(r);
    endtask

    // Expected upstream beats; an early rlast from the slave truncates the burst.
    task automatic expectBurst(input logic p, input req_t r);
        beat_t e;
        for (int b = 0; b <= int'(r.len); b++) begin
            e.port = p;
            e.data = {24'h0, r.addr, 8'(b)};
            e.resp = 2'(b);
            e.id   = r.id;
            e.last = (b == int'(r.len)) || (b == early_at);
            exp_q.push_back(e);
            if (e.last) break;
        end
    endtask

    task automatic waitIdle(input string tag, input int budget);
        logic done;
        done = 1'b0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk);
            done = (pend0.size() == 0) && (pend1.size() == 0) && (exp_q.size() == 0) && !busy;
        end
        checkOutput({tag, "_done"}, 64'(done), 64'd1);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
        checkOutput({tag, "_grant"}, 64'(grant), 64'd0);
        checkOutput({tag, "_rlast_err"}, 64'(rlast_err), 64'd0);
        checkOutput({tag, "_m_arvalid"}, 64'(m_axi_arvalid), 64'd0);
        checkOutput({tag, "_m_araddr"}, 64'(m_axi_araddr), 64'd0);
        checkOutput({tag, "_m_arlen"}, 64'(m_axi_arlen), 64'd0);
        checkOutput({tag, "_m_arid"}, 64'(m_axi_arid), 64'd0);
        checkOutput({tag, "_m_rready"}, 64'(m_axi_rready), 64'd0);
        checkOutput({tag, "_s_rvalid"}, 64'({s0_axi_rvalid, s1_axi_rvalid}), 64'd0);
        checkOutput({tag, "_s_arready"}, 64'({s0_axi_arready, s1_axi_arready}), 64'd0);
    endtask

    task automatic pulseReset(input string tag);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkResetOutputs(tag);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        grant_log.delete();
    endtask

    function automatic logic [63:0] grantSeq();
        logic [63:0] s;
        s = 64'd0;
        foreach (grant_log[i]) s = (s << 4) | 64'(grant_log[i]);
        return s;
    endfunction

    // Bus model: monitors at negedge, drives requesters and slave at posedge+1.
    initial begin
        s0_axi_arvalid = 1'b0; s0_axi_araddr = '0; s0_axi_arid = '0; s0_axi_arlen = '0;
        s0_axi_arsize = 3'd3; s0_axi_arburst = 2'd1; s0_axi_rready = 1'b0;
        s1_axi_arvalid = 1'b0; s1_axi_araddr = '0; s1_axi_arid = '0; s1_axi_arlen = '0;
        s1_axi_arsize = 3'd2; s1_axi_arburst = 2'd2; s1_axi_rready = 1'b0;
        m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
        m_axi_rdata = '0; m_axi_rresp = '0; m_axi_rid = '0;
        sl_active = 1'b0; sl_addr = '0; sl_len = '0; sl_beat = '0; sl_id = '0;
        prev_up_hs = 1'b0; prev_port = 1'b0; prev_mar_wait = 1'b0; prev_last = 1'b0;
        prev_araddr = '0;
        forever begin
            @(negedge clk);
            s0_hs = 1'b0; s1_hs = 1'b0; mar_hs = 1'b0; mr_hs = 1'b0; mar_seen = 1'b0;
            if (rst_n) begin
                s0_hs    = s0_axi_arvalid && s0_axi_arready;
                s1_hs    = s1_axi_arvalid && s1_axi_arready;
                mar_hs   = m_axi_arvalid && m_axi_arready;
                mr_hs    = m_axi_rvalid && m_axi_rready;
                mr_last  = m_axi_rlast;
                mar_seen = m_axi_arvalid;
                cap_addr = m_axi_araddr; cap_len = m_axi_arlen; cap_id = m_axi_arid;
                u0       = s0_axi_rvalid && s0_axi_rready;
                u1       = s1_axi_rvalid && s1_axi_rready;
                if (prev_up_hs) begin
                    checkOutput("ar_latency", 64'(m_axi_arvalid), 64'd1);
                    checkOutput("ar_addr_fwd", 64'(m_axi_araddr), 64'(prev_req.addr));
                    checkOutput("ar_len_fwd", 64'(m_axi_arlen), 64'(prev_req.len));
                    checkOutput("ar_id_fwd", 64'(m_axi_arid), 64'(prev_req.id));
                    checkOutput("ar_size_fwd", 64'(m_axi_arsize), prev_port ? 64'd2 : 64'd3);
                    checkOutput("grant", 64'(grant), 64'(prev_port));
                end
                if (prev_mar_wait) begin
                    checkOutput("ar_stable_valid", 64'(m_axi_arvalid), 64'd1);
                    checkOutput("ar_stable_addr", 64'(m_axi_araddr), 64'(prev_araddr));
                end
                if (prev_last) begin
                    checkOutput("busy_after_last", 64'(busy), 64'd0);
                    if (s0_axi_arvalid || s1_axi_arvalid)
                        checkOutput("no_idle_gap", 64'(s0_axi_arready | s1_axi_arready), 64'd1);
                end
                if (busy)
                    checkOutput("arready_busy", 64'({s0_axi_arready, s1_axi_arready}), 64'd0);
                if (!busy || m_axi_arvalid)
                    checkOutput("r_quiet", 64'({s0_axi_rvalid, s1_axi_rvalid, m_axi_rready}), 64'd0);
                if (s0_axi_rvalid || s1_axi_rvalid)
                    checkOutput("rready_route", 64'(m_axi_rready),
                                64'(s0_axi_rvalid ? s0_axi_rready : s1_axi_rready));
                prev_up_hs    = 1'b0;
                prev_mar_wait = m_axi_arvalid && !m_axi_arready;
                prev_araddr   = m_axi_araddr;
                prev_last     = 1'b0;
                if (s0_hs || s1_hs) begin
                    port    = s1_hs;
                    exp_win = (s0_axi_arvalid && s1_axi_arvalid) ? ~tb_last : s1_axi_arvalid;
                    checkOutput("accept_count", 64'(s0_hs) + 64'(s1_hs), 64'd1);
                    checkOutput("winner", 64'(port), 64'(exp_win));
                    checkOutput("ar_idle_arvalid", 64'(m_axi_arvalid), 64'd0);
                    tb_last = port;
                    grant_log.push_back(int'(port));
                    prev_req = port ? pend1[0] : pend0[0];
                    prev_port = port;
                    prev_up_hs = 1'b1;
                    expectBurst(port, prev_req);
                end
                if (u0 || u1) begin
                    checkOutput("beat_expected", 64'(exp_q.size() != 0), 64'd1);
                    if (exp_q.size() != 0) begin
                        eb = exp_q.pop_front();
                        checkOutput("beat_port", 64'(u1), 64'(eb.port));
                        checkOutput("rvalid_other", 64'(eb.port ? s0_axi_rvalid : s1_axi_rvalid), 64'd0);
                        checkOutput("rdata", eb.port ? s1_axi_rdata : s0_axi_rdata, eb.data);
                        checkOutput("rresp", 64'(eb.port ? s1_axi_rresp : s0_axi_rresp), 64'(eb.resp));
                        checkOutput("rid", 64'(eb.port ? s1_axi_rid : s0_axi_rid), 64'(eb.id));
                        checkOutput("rlast", 64'(eb.port ? s1_axi_rlast : s0_axi_rlast), 64'(eb.last));
                        beats_seen++;
                        if (eb.last) prev_last = 1'b1;
                    end
                end
            end else begin
                prev_up_hs = 1'b0; prev_mar_wait = 1'b0; prev_last = 1'b0;
            end
            @(posedge clk);
            #1;
            if (!rst_n) begin
                sl_active = 1'b0;
                tb_last   = 1'b1;
            end else begin
                if (s0_hs) void'(pend0.pop_front());
                if (s1_hs) void'(pend1.pop_front());
                if (mar_hs) begin
                    sl_active = 1'b1; sl_addr = cap_addr; sl_len = cap_len;
                    sl_id = cap_id; sl_beat = 8'd0;
                end else if (mr_hs) begin
                    if (mr_last) sl_active = 1'b0;
                    else         sl_beat = sl_beat + 8'd1;
                end
                if (mar_seen && stall_cnt > 0) stall_cnt--;
            end
            m_axi_arready = rst_n && !sl_active && (stall_cnt == 0);
            m_axi_rvalid  = sl_active;
            m_axi_rdata   = {24'h0, sl_addr, sl_beat};
            m_axi_rresp   = sl_beat[1:0];
            m_axi_rid     = sl_id;
            m_axi_rlast   = sl_active && ((sl_beat == sl_len) || (int'(sl_beat) == early_at));
            s0_axi_arvalid = (pend0.size() != 0);
            if (pend0.size() != 0) begin
                s0_axi_araddr = pend0[0].addr; s0_axi_arlen = pend0[0].len; s0_axi_arid = pend0[0].id;
            end
            s1_axi_arvalid = (pend1.size() != 0);
            if (pend1.size() != 0) begin
                s1_axi_araddr = pend1[0].addr; s1_axi_arlen = pend1[0].len; s1_axi_arid = pend1[0].id;
            end
            s0_axi_rready = rr_toggle ? 1'($urandom_range(0, 1)) : 1'b1;
            s1_axi_rready = rr_toggle ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        #2;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        checkResetOutputs("rst_init");
        rst_n = 1'b1;

        beats_seen = 0;
        applyStimulus(1'b0, 32'h100, 8'd3, 4'h1);
        waitIdle("s0_only", 200);
        checkOutput("s0_only_beats", 64'(beats_seen), 64'd4);
        checkOutput("s0_only_err", 64'(rlast_err), 64'd0);

        pulseReset("rst_tie");
        applyStimulus(1'b0, 32'h200, 8'd1, 4'h2);
        applyStimulus(1'b1, 32'h280, 8'd2, 4'h3);
        waitIdle("tie", 200);
        checkOutput("tie_count", 64'(grant_log.size()), 64'd2);
        checkOutput("tie_seq", grantSeq(), 64'h01);

        grant_log.delete();
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, 32'h1000 + 32'(i * 64), 8'd2, 4'h4);
            applyStimulus(1'b1, 32'h1800 + 32'(i * 64), 8'd1, 4'h6);
        end
        waitIdle("rr", 300);
        checkOutput("rr_count", 64'(grant_log.size()), 64'd4);
        checkOutput("rr_seq", grantSeq(), 64'h0101);

        stall_cnt = 5;
        applyStimulus(1'b1, 32'h2000, 8'd2, 4'h5);
        waitIdle("stall", 200);

        beats_seen = 0;
        applyStimulus(1'b1, 32'hABC0, 8'd255, 4'h7);
        waitIdle("len255", 800);
        checkOutput("len255_beats", 64'(beats_seen), 64'd256);
        checkOutput("len255_err", 64'(rlast_err), 64'd0);

        early_at = 0;
        beats_seen = 0;
        applyStimulus(1'b0, 32'h300, 8'd1, 4'h2);
        waitIdle("early", 200);
        checkOutput("early_err", 64'(rlast_err), 64'd1);
        checkOutput("early_beats", 64'(beats_seen), 64'd1);
        early_at = -1;

        rr_toggle = 1'b1;
        beats_seen = 0;
        applyStimulus(1'b0, 32'h400, 8'd7, 4'h3);
        for (int i = 0; i < 200 && beats_seen < 3; i++) @(negedge clk);
        checkOutput("mid_reached", 64'(beats_seen >= 3), 64'd1);
        pulseReset("rst_mid");
        beats_seen = 0;
        applyStimulus(1'b0, 32'h500, 8'd7, 4'h9);
        waitIdle("after_rst", 400);
        checkOutput("after_rst_beats", 64'(beats_seen), 64'd8);
        checkOutput("after_rst_err", 64'(rlast_err), 64'd0);
        rr_toggle = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
